// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-organised, big-endian data memory.
// Optional misaligned-access trap is compiled in with `define MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned WORD_IDX_BITS = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_enable_o,
  output logic        mem_read_enable_o,
  input  logic [31:0] mem_rdata_i
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err_o
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_READ,
    S_RMW_WRITE
`ifdef MISALIGN_TRAP_EN
    ,
    S_ERR
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [HW-1:0]   wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic            misalign_q, misalign_d;
  logic            misaligned_c;
  logic            unused_addr_bits;

  // Address bits above the word index are dropped; memory wraps.
  assign unused_addr_bits = ^req_addr_i;

  // Big-endian lane extraction with sign/zero extension.
  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sgn);
    logic [7:0]    b;
    logic [HW-1:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed sub-word lane of w with store data.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [HW-1:0] wd);
    logic [DW-1:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = wd;
    end else begin
      r[31:16] = wd;
    end
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign misaligned_c = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                        (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      misalign_q   <= misalign_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    misalign_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          off_d      = req_addr_i[1:0];
          size_d     = req_size_i;
          signed_d   = req_signed_i;
          wdata_d    = req_wdata_i[HW-1:0];
          mem_addr_d = DW'(req_addr_i[WORD_IDX_BITS+1:2]);
          if (misaligned_c) begin
`ifdef MISALIGN_TRAP_EN
            state_d = S_ERR;
`endif
          end else if (!req_write_i) begin
            state_d = S_LOAD;
          end else if (req_size_i[1]) begin
            state_d     = S_STORE;
            mem_wdata_d = req_wdata_i;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        resp_rdata_d = load_ext(mem_rdata_i, off_q, size_q, signed_q);
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_RMW_READ: begin
        mem_wdata_d = merge(mem_rdata_i, off_q, size_q, wdata_q);
        state_d     = S_RMW_WRITE;
      end
      S_STORE, S_RMW_WRITE: begin
        resp_rdata_d = '0;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
`ifdef MISALIGN_TRAP_EN
      S_ERR: begin
        resp_rdata_d = '0;
        resp_valid_d = 1'b1;
        misalign_d   = 1'b1;
        state_d      = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Memory interface is quiet whenever the unit is idle.
    if (state_d == S_IDLE) begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
    mem_re_d    = (state_d == S_LOAD) || (state_d == S_RMW_READ);
    mem_we_d    = (state_d == S_STORE) || (state_d == S_RMW_WRITE);
    req_ready_d = (state_d == S_IDLE);
  end

  assign req_ready_o        = req_ready_q;
  assign resp_valid_o       = resp_valid_q;
  assign resp_rdata_o       = resp_rdata_q;
  assign mem_addr_o         = mem_addr_q;
  assign mem_wdata_o        = mem_wdata_q;
  assign mem_read_enable_o  = mem_re_q;
  assign mem_write_enable_o = mem_we_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err_o     = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
// Expectations follow MISALIGN_TRAP_EN when that macro is defined.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  load_store_unit #(.WORD_IDX_BITS(8)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_enable_o(mem_we),
    .mem_read_enable_o(mem_re), .mem_rdata_i(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err_o(misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  logic [31:0] mem [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(negedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: strobe sanity every cycle, scoreboard pop on each response.
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      chk("strobe_exclusive", 32'(mem_we && mem_re), 32'd0);
      chk("mem_addr_upper", mem_addr >> 8, 32'd0);
    end else begin
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_wdata", mem_wdata, 32'd0);
    end
    if (mem_we) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (mem_re) rd_cnt++;
`ifdef MISALIGN_TRAP_EN
    if (!resp_valid) chk("misalign_idle", 32'(misalign_err), 32'd0);
`endif
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", cyc - e.cyc, e.lat);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_err", 32'(misalign_err), 32'(e.err));
`endif
      end
    end
  end

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && req_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("completion_timeout", 32'(done), 32'd1);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int unsigned lat);
    exp_t e;
    @(negedge clk);
    drive(w, sz, sg, a, wd);
    e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done();
  endtask

  int unsigned wr0, rd0, c0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    reset_n = 1'b1;

    // Word store, single write cycle at word index 4.
    wr0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8000FF7F, 32'h0, 1'b0, 2);
    chk("st_word_wr_cycles", wr_cnt - wr0, 32'd1);
    chk("st_word_addr", last_wr_addr, 32'h4);
    chk("st_word_data", last_wr_data, 32'h8000FF7F);

    // Byte/half loads with extension.
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000007F, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFF8000, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000FF7F, 1'b0, 2);

    // Byte store via read-modify-write.
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h0, 1'b0, 3);
    chk("rmw_rd_cycles", rd_cnt - rd0, 32'd1);
    chk("rmw_wr_cycles", wr_cnt - wr0, 32'd1);
    chk("rmw_merged", last_wr_data, 32'h80ABFF7F);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ABFF7F, 1'b0, 2);

    // Reset during RMW_READ: no write must reach memory.
    wr0 = wr_cnt;
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_strobe", 32'(mem_re), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_write", wr_cnt - wr0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ABFF7F, 1'b0, 2);

    // Back-to-back loads with req_valid held high.
    begin
      exp_t e;
      @(negedge clk);
      drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      c0 = cyc;
      e.rdata = 32'h80ABFF7F; e.err = 1'b0; e.cyc = c0; e.lat = 2;
      sb.push_back(e);
      @(negedge clk);
      #1 chk("b2b_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1 chk("b2b_ready_high", 32'(req_ready), 32'd1);
      e.cyc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_done();
    end

    // Misaligned word load and halfword store.
    wr0 = wr_cnt; rd0 = rd_cnt;
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 2);
    chk("mis_ld_no_read", rd_cnt - rd0, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, 32'h0, 1'b1, 2);
    chk("mis_st_no_write", wr_cnt - wr0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ABFF7F, 1'b0, 2);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h80ABFF7F, 1'b0, 2);
    chk("align_ld_read", rd_cnt - rd0, 32'd1);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, 32'h0, 1'b0, 3);
    chk("align_half_merged", last_wr_data, 32'h80AB1234);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80AB1234, 1'b0, 2);
`endif

    // Address wrap: 0x410 aliases word index 4.
    issue(1'b1, 2'b11, 1'b0, 32'h410, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    chk("wrap_addr", last_wr_addr, 32'h4);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFCA, 1'b0, 2);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
